// File: rtl/pipe_stall_ctrl_if.sv
// Bundle between the pipeline hazard sources and the central stall controller.
// The pipeline side uses the master modport; pipe_stall_ctrl uses the slave modport.
interface pipe_stall_ctrl_if #(
    parameter int STALL_W   = 2,
    parameter int ADDR_W    = 32,
    parameter int REGADDR_W = 5,
    parameter int CNT_W     = 32
);
    logic                 if_wait_i;
    logic [REGADDR_W-1:0] id_rs1_addr_i;
    logic                 id_rs1_read_i;
    logic [REGADDR_W-1:0] id_rs2_addr_i;
    logic                 id_rs2_read_i;
    logic [REGADDR_W-1:0] ex_rd_addr_i;
    logic                 ex_rd_load_i;
    logic                 mem_busy_i;
    logic                 branch_error_i;
    logic [ADDR_W-1:0]    redirect_pc_i;

    logic [STALL_W-1:0]   stall_pc_o;
    logic [STALL_W-1:0]   stall_if_id_o;
    logic [STALL_W-1:0]   stall_id_ex_o;
    logic [STALL_W-1:0]   stall_ex_mem_o;
    logic [STALL_W-1:0]   stall_mem_wb_o;
    logic                 flush_o;
    logic [ADDR_W-1:0]    redirect_pc_o;
    logic [CNT_W-1:0]     stall_cycles_o;
    logic [CNT_W-1:0]     flush_count_o;

    modport master (
        output if_wait_i, id_rs1_addr_i, id_rs1_read_i, id_rs2_addr_i, id_rs2_read_i,
               ex_rd_addr_i, ex_rd_load_i, mem_busy_i, branch_error_i, redirect_pc_i,
        input  stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o,
               flush_o, redirect_pc_o, stall_cycles_o, flush_count_o
    );

    modport slave (
        input  if_wait_i, id_rs1_addr_i, id_rs1_read_i, id_rs2_addr_i, id_rs2_read_i,
               ex_rd_addr_i, ex_rd_load_i, mem_busy_i, branch_error_i, redirect_pc_i,
        output stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o,
               flush_o, redirect_pc_o, stall_cycles_o, flush_count_o
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central hazard/stall controller: arbitrates MEM busy, mispredict flush, load-use and
// fetch wait, keeping a pending flush across freezes. Define STALL_PERF_EN for counters.
module pipe_stall_ctrl #(
    parameter int STALL_W   = 2,
    parameter int ADDR_W    = 32,
    parameter int REGADDR_W = 5,
    parameter int CNT_W     = 32
) (
    input logic              clk,
    input logic              rst_n,
    pipe_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        PASS = 2'b00,
        HOLD = 2'b01,
        BUBB = 2'b10
    } stall_e;

    stall_e            stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic              flush;
    logic [ADDR_W-1:0] redirect_pc;

    logic              pend;
    logic [ADDR_W-1:0] pend_pc;
    logic              fl;
    logic [ADDR_W-1:0] target;
    logic              lu;

    assign fl     = bus.branch_error_i | pend;
    // A fresh mispredict pulse supersedes any older pending target.
    assign target = bus.branch_error_i ? bus.redirect_pc_i : pend_pc;

    assign lu = bus.ex_rd_load_i && (bus.ex_rd_addr_i != '0) &&
                ((bus.id_rs1_read_i && (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) ||
                 (bus.id_rs2_read_i && (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));

    always_comb begin
        // NOTE: every output gets a default first so no path through the priority chain infers a latch.
        stall_pc     = PASS;
        stall_if_id  = PASS;
        stall_id_ex  = PASS;
        stall_ex_mem = PASS;
        stall_mem_wb = PASS;
        flush        = 1'b0;
        redirect_pc  = '0;
        if (!rst_n) begin
            stall_pc     = BUBB;
            stall_if_id  = BUBB;
            stall_id_ex  = BUBB;
            stall_ex_mem = BUBB;
            stall_mem_wb = BUBB;
        end else if (bus.mem_busy_i) begin
            stall_pc     = HOLD;
            stall_if_id  = HOLD;
            stall_id_ex  = HOLD;
            stall_ex_mem = HOLD;
            stall_mem_wb = BUBB;
        end else if (fl) begin
            stall_if_id  = BUBB;
            stall_id_ex  = BUBB;
            flush        = 1'b1;
            redirect_pc  = target;
        end else if (lu) begin
            stall_pc     = HOLD;
            stall_if_id  = HOLD;
            stall_id_ex  = BUBB;
        end else if (bus.if_wait_i) begin
            stall_pc     = HOLD;
            stall_if_id  = BUBB;
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            pend_pc <= '0;
        end else if (fl && bus.mem_busy_i) begin
            pend    <= 1'b1;
            pend_pc <= target;
        end else if (flush) begin
            pend    <= 1'b0;
        end
    end

    assign bus.stall_pc_o     = stall_pc;
    assign bus.stall_if_id_o  = stall_if_id;
    assign bus.stall_id_ex_o  = stall_id_ex;
    assign bus.stall_ex_mem_o = stall_ex_mem;
    assign bus.stall_mem_wb_o = stall_mem_wb;
    assign bus.flush_o        = flush;
    assign bus.redirect_pc_o  = redirect_pc;

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_pc != PASS) stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush)            flush_count  <= flush_count + CNT_W'(1);
        end
    end

    assign bus.stall_cycles_o = stall_cycles;
    assign bus.flush_count_o  = flush_count;
`else
    assign bus.stall_cycles_o = '0;
    assign bus.flush_count_o  = '0;
`endif
endmodule
